// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO that feeds a downstream UART transmitter one byte at a time.
// A byte is popped into the tx_data register, announced with a one-cycle
// tx_send pulse, and the feeder then waits for the transmitter to raise and
// drop tx_busy before launching the next byte. If tx_busy never rises within
// BUSY_TIMEOUT cycles the same byte is launched again without a new pop.
//
// Parameters
//   DEPTH         FIFO depth in bytes, power of two, 2..256
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise before relaunch, 1..15
//
// Ports
//   clk       clock, all state updates on its rising edge
//   rst       asynchronous active-high reset
//   in_data   byte offered for buffering
//   in_valid  in_data is valid
//   in_ready  FIFO can accept a byte (not full, not in reset)
//   tx_send   single-cycle start pulse to the transmitter
//   tx_data   byte presented to the transmitter
//   tx_busy   transmitter busy
//   empty     FIFO holds 0 bytes
//   full      FIFO holds DEPTH bytes
//   level     occupancy, present only when UART_TX_FEEDER_LEVEL_EN is defined
//
// Build option
//   UART_TX_FEEDER_LEVEL_EN  adds the level output port and its logic.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for a buffered byte and an idle transmitter
// LAUNCH    | tx_send high for this single cycle
// WAIT_BUSY | waiting for tx_busy to rise, relaunch on timeout
// WAIT_DONE | transmitter busy, waiting for tx_busy to fall

module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       empty,
    output logic       full
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    // Timeout is a down-counter loaded on entry to WAIT_BUSY; relaunch fires
    // at terminal count, giving BUSY_TIMEOUT cycles in WAIT_BUSY.
    localparam logic [3:0] TMO_LOAD = 4'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [3:0]  tmo_cnt;
    logic        wr_en;
    logic        pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // addresses with differing wrap bits mean full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // No bypass: a pop in the same cycle does not let a full FIFO accept.
    assign in_ready = !full && !rst;
    assign wr_en    = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty && !tx_busy;

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            tmo_cnt <= '0;
            tx_send <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr[AW-1:0]];
                        rd_ptr  <= rd_ptr + 1'b1;
                        tx_send <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_send <= 1'b0;
                    tmo_cnt <= TMO_LOAD;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end else if (tmo_cnt == 4'd0) begin
                        // Transmitter missed the pulse: resend the held byte.
                        tx_send <= 1'b1;
                        state   <= LAUNCH;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: a queue-based reference model predicts the
// outputs every cycle, a transmitter model drives tx_busy, and directed
// scenarios pin latency, full/no-bypass, draining order, timeout resend and
// reset behaviour before a randomized run.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int BT    = 4;
    localparam int AW    = $clog2(DEPTH);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic       in_ready;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       empty;
    logic       full;
`ifdef UART_TX_FEEDER_LEVEL_EN
    logic [AW:0] level;
`endif

    uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx_send(tx_send),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .empty(empty),
        .full(full)
`ifdef UART_TX_FEEDER_LEVEL_EN
        ,
        .level(level)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered bytes, held byte and transfer progress.
    byte unsigned mq[$];
    logic [7:0]   m_cur = 8'h00;
    bit           m_launch = 0;    // a start pulse is due this cycle
    bit           m_await = 0;     // pulse sent, transmitter not yet busy
    bit           m_done_wait = 0; // transmitter busy with the held byte
    int           m_wait_n = 0;    // idle-busy cycles since the pulse

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit nl;
        if (rst) begin
            mq.delete();
            m_cur = 8'h00;
            m_launch = 0;
            m_await = 0;
            m_done_wait = 0;
            m_wait_n = 0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            nl = 0;
            if (m_launch) begin
                m_await = 1;
                m_wait_n = 0;
            end else if (m_await) begin
                if (tx_busy) begin
                    m_await = 0;
                    m_done_wait = 1;
                end else begin
                    m_wait_n++;
                    if (m_wait_n == BT) begin
                        m_await = 0;
                        nl = 1;
                    end
                end
            end else if (m_done_wait) begin
                if (!tx_busy) m_done_wait = 0;
            end else if (mq.size() > 0 && !tx_busy) begin
                m_cur = mq.pop_front();
                nl = 1;
            end
            if (acc) mq.push_back(in_data);
            m_launch = nl;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("tx_send", int'(tx_send), int'(m_launch));
        check("tx_data", int'(tx_data), int'(m_cur));
        check("empty", int'(empty), int'(mq.size() == 0));
        check("full", int'(full), int'(mq.size() == DEPTH));
        check("in_ready", int'(in_ready), int'(!rst && mq.size() < DEPTH));
`ifdef UART_TX_FEEDER_LEVEL_EN
        check("level", int'(level), mq.size());
`endif
    end

    // Transmitter model and stimulus bookkeeping.
    int         bmode = 1;   // 0: busy tied low, 1: responds to tx_send, 2: busy held high
    int         blen = 3;
    bit         brand = 0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         n_sends = 0;
    logic [7:0] sent[$];
    int         send_cyc[$];

    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        if (tx_send) begin
            n_sends++;
            sent.push_back(tx_data);
            send_cyc.push_back(cyc);
        end
        in_valid = v;
        in_data  = d;
        case (bmode)
            0: tx_busy = 1'b0;
            2: tx_busy = 1'b1;
            default: begin
                if (tx_send) begin
                    tx_busy  = 1'b1;
                    busy_cnt = (brand ? int'($urandom_range(1, 10)) : blen) - 1;
                end else if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit found;
        logic [7:0] exp_b;

        repeat (3) @(negedge clk);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_tx_send", int'(tx_send), 0);
        check("rst_tx_data", int'(tx_data), 0);
        #2 rst = 1'b0;
        step(0, 8'h00);
        check("ready_after_rst", int'(in_ready), 1);

        // Single byte latency: write in cycle C, pulse in C+2.
        base = n_sends;
        step(1, 8'hA5);
        step(0, 8'h00);
        check("a5_no_early_send", int'(tx_send), 0);
        check("a5_not_empty", int'(empty), 0);
        step(0, 8'h00);
        check("a5_send_c2", int'(tx_send), 1);
        check("a5_data", int'(tx_data), 8'hA5);
        check("a5_empty_after_pop", int'(empty), 1);
        repeat (10) step(0, 8'h00);
        check("a5_pulse_count", n_sends - base, 1);

        // Fill with busy held, 17th write rejected.
        bmode = 2;
        sent.delete();
        for (int i = 1; i <= 16; i++) step(1, 8'(i));
        step(0, 8'h00);
        check("fill_full", int'(full), 1);
        check("fill_in_ready", int'(in_ready), 0);
        step(1, 8'h11);
        step(1, 8'h55);   // busy drops here, so the pop coincides with 0x55
        check("rej_11_full", int'(full), 1);
        bmode = 1;
        blen = 2;
        busy_cnt = 0;
        tx_busy = 1'b0;
        step(0, 8'h00);
        check("pop_55_full_drops", int'(full), 0);
        check("pop_55_in_ready", int'(in_ready), 1);
`ifdef UART_TX_FEEDER_LEVEL_EN
        check("pop_55_level", int'(level), 15);
`endif
        found = 0;
        for (int k = 0; k < 400; k++) begin
            step(0, 8'h00);
            if (sent.size() >= 16 && mq.size() == 0 && !m_launch && !m_await && !m_done_wait) begin
                found = 1;
                break;
            end
        end
        check("drain_done", int'(found), 1);
        repeat (10) step(0, 8'h00);
        check("drain_count", sent.size(), 16);
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            exp_b = 8'(i + 1);
            check("drain_order", int'(sent[i]), int'(exp_b));
        end

        // Busy never rises: periodic resend of the same byte.
        bmode = 0;
        sent.delete();
        send_cyc.delete();
        step(1, 8'h3C);
        repeat (30) step(0, 8'h00);
        check("to_pulse_count_ok", int'(send_cyc.size() >= 5), 1);
        for (int i = 1; i < send_cyc.size(); i++) begin
            check("to_period", send_cyc[i] - send_cyc[i-1], BT + 1);
            check("to_data", int'(sent[i]), 8'h3C);
        end
        check("to_empty", int'(empty), 1);

        // Reset during WAIT_DONE with five bytes queued.
        @(negedge clk);
        #2 rst = 1'b1;
        bmode = 1;
        busy_cnt = 0;
        tx_busy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        blen = 20;
        for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i));
        found = 0;
        for (int k = 0; k < 60; k++) begin
            if (m_done_wait && mq.size() == 5) begin
                found = 1;
                break;
            end
            step(0, 8'h00);
        end
        check("wd_reached", int'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx_send", int'(tx_send), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_in_ready", int'(in_ready), 0);
`ifdef UART_TX_FEEDER_LEVEL_EN
        check("mid_rst_level", int'(level), 0);
`endif
        busy_cnt = 0;
        tx_busy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        base = n_sends;
        step(0, 8'h00);
        check("post_rst_ready", int'(in_ready), 1);
        repeat (30) step(0, 8'h00);
        check("post_rst_no_send", n_sends - base, 0);
        check("post_rst_empty", int'(empty), 1);

        // Randomized traffic with varying transmitter behaviour.
        brand = 1;
        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 0) bmode = int'($urandom_range(0, 2));
            step(1'($urandom_range(0, 1)), 8'($urandom));
        end
        bmode = 1;
        repeat (20) step(0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
